// File: rtl/ins_pkg.sv
// Shared constants and helpers for the ins bus sink.
package ins_pkg;

    localparam int INS_WIDTH_DEFAULT = 3;

    // Wide enough for any practical counter width (up to 63 bits).
    typedef logic [63:0] cnt_sat_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic cnt_sat_t cnt_max(input int w);
        return (cnt_sat_t'(1) << w) - cnt_sat_t'(1);
    endfunction

endpackage

// File: rtl/ins_sink_if.sv
// Valid/ready word channel; master drives data, slave drives ready.
interface ins_sink_if
    import ins_pkg::*;
#(
    parameter int WIDTH = INS_WIDTH_DEFAULT
);
    logic             valid;
    logic [WIDTH-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ins_sink_mem.sv
// Storage array for the sink FIFO: synchronous write, asynchronous read
// so the head word falls through with no extra cycle.
module ins_sink_mem #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ins_sink.sv
// Receiving FIFO for the ins bus with occupancy and a saturating
// count of accepted words.
module ins_sink
    import ins_pkg::*;
#(
    parameter int WIDTH = INS_WIDTH_DEFAULT,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ins_sink_if.slave                 i_ins,
    ins_sink_if.master                o_out,
    output logic [lvl_w(DEPTH)-1:0]   o_level,
    output logic [CNT_W-1:0]          o_xfer_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic             w_ready;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_rdata;

    // Ready comes from registered level only, so a pop while full never
    // opens the input in the same cycle.
    assign w_ready = (r_level != LW'(DEPTH));
    assign w_valid = (r_level != '0);
    assign w_push  = i_ins.valid & w_ready;
    assign w_pop   = w_valid & o_out.ready;

    assign i_ins.ready = w_ready;
    assign o_out.valid = w_valid;
    assign o_out.data  = w_rdata;
    assign o_level     = r_level;
    assign o_xfer_cnt  = r_xfer_cnt;

    ins_sink_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_ins.data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_xfer_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_xfer_cnt != CNT_MAX) begin
                    r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: doc/ins_sink.md
# ins_sink

Receiving end of the parameterised `ins` bus: accepts WIDTH-bit words from an `ins` producer under a valid/ready handshake and buffers them in a small FIFO. It presents the buffered words to a downstream consumer. It also keeps a saturating count of accepted words for status readout. It sits directly after any `ins` producer instance and takes that instance's WIDTH parameter value unchanged.

## Interface
- WIDTH, 3, width of the `ins` data word; ≥1
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_W, 16, width of the accepted-word counter
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- ins_valid  input  1  producer has a word on `ins`
- ins  input  WIDTH  producer data word
- ins_ready  output  1  sink can accept; depends only on registered state
- out_valid  output  1  head word available
- out_data  output  WIDTH  head word
- out_ready  input  1  consumer takes head word
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- xfer_cnt  output  CNT_W  accepted words, saturating

## Operation
- Push = ins_valid & ins_ready; pop = out_valid & out_ready.
- Storage: DEPTH-entry array; write pointer and read pointer of $clog2(DEPTH) bits, wrapping naturally DEPTH-1 → 0.
- level register: +1 on push-only, −1 on pop-only, unchanged on both or neither.
- ins_ready = (level != DEPTH). Registered-state only; no combinational path from out_ready. When full, a push is not accepted even if a pop occurs in the same cycle.
- out_valid = (level != 0); out_data = mem[rd_ptr] (first-word fall-through from the registered array).
- Empty with ins_valid: the word is written; pop is impossible that cycle because out_valid=0.
- Full with pop: level goes DEPTH → DEPTH−1; ins_ready rises the next cycle.
- xfer_cnt increments on each push and saturates at 2^CNT_W−1 (no wrap).
- Data is never dropped, reordered or duplicated.
- The X value on `ins` while ins_valid=0 must not be written.
- Reset mid-stream: all stored words are discarded. Pointers, level and xfer_cnt clear immediately on rst_n fall.

## Timing
- Reset values: ins_ready=1, out_valid=0, level=0, xfer_cnt=0. out_data=mem[0] contents (don't-care while out_valid=0).
- Push at edge N → out_valid=1 and out_data valid after edge N, usable by the consumer in cycle N+1 (latency 1).
- Pop at edge N → next entry visible after edge N (zero-bubble back-to-back).
- Sustained push+pop every cycle at any nonzero level: throughput 1 word/cycle, level constant.
- Reset release: first push may be accepted on the first rising edge with rst_n=1.

## Structure
- Package `ins_pkg`:
  - constant `INS_WIDTH_DEFAULT = 3`;
  - function `lvl_w(depth)` returning $clog2(depth)+1;
  - typedef for the counter saturation max.
- Sub-module `ins_sink_mem`: DEPTH×WIDTH register array with write enable, write address and read address. No reset on the data array.
- Top holds pointers, level, handshake logic and counter.

## Test plan
- Reset, then push 3'b101, 3'b010 on consecutive cycles with out_ready=0 → level=2, out_data=3'b101, xfer_cnt=2.
- Fill 4 words with out_ready=0 → ins_ready=0 at level=4. A fifth ins_valid is held off, and xfer_cnt stays 4.
- Full, then out_ready=1 and ins_valid=1 in the same cycle → pop only, level=3. Push accepted the next cycle, level back to 4.
- Stream 0..7 with out_ready toggling randomly → output sequence 0..7 exact. Pointers wrap twice with no loss.
- CNT_W=4, 20 pushes with out_ready=1 → xfer_cnt stops at 15.
- Assert rst_n low mid-stream at level=3 → out_valid=0, level=0, xfer_cnt=0 without waiting for a clk edge.
